// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: FSM encoding and default parameters shared by the PWM capture block
package pwm_capture_pkg;
    typedef enum logic [1:0] {ARM, HIGH, LOW} state_t;
    localparam int DEF_WIDTH = 16;
    localparam int unsigned DEF_TIMEOUT = 32'h0000_FFFF;
    localparam int BLANK_CYCLES = 3;
endpackage

// File: rtl/pwm_capture_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer with registered rise/fall pulses, rise blanked right after reset
module sync_edge_detect
    import pwm_capture_pkg::*;
(
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;
    logic [1:0] blank;
    // blank keeps a level already high at reset release from looking like a rising edge
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            blank <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= sig_in;
            s2    <= s1;
            s3    <= s2;
            blank <= blank + 2'(blank != 2'(BLANK_CYCLES));
            rise  <= s2 & ~s3 & (blank == 2'(BLANK_CYCLES));
            fall  <= ~s2 & s3;
        end
    end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a slow asynchronous pulse train in clk_in cycles
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int          WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);
    if (WIDTH < 2 || WIDTH > 32 || 64'(TIMEOUT) > (64'd1 << WIDTH) - 64'd1) begin : g_bad_param
        $error("pwm_capture: TIMEOUT must fit in WIDTH bits and WIDTH must be 2..32");
    end

    localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             rise, fall;
    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n, hreg, hreg_n, period_n, high_n;
    logic             valid_n, timeout_n;

    sync_edge_detect u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= ARM;
            cnt       <= '0;
            hreg      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hreg      <= hreg_n;
            period    <= period_n;
            high_time <= high_n;
            valid     <= valid_n;
            timeout   <= timeout_n;
        end
    end

    // edges take priority over the timeout check; the counter saturates instead of wrapping
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + WIDTH'(cnt != '1);
        hreg_n    = hreg;
        period_n  = period;
        high_n    = high_time;
        valid_n   = 1'b0;
        timeout_n = timeout;
        if (state == ARM) begin
            cnt_n = rise ? ONE : cnt;
            if (rise) state_n = HIGH;
        end else if (rise) begin
            state_n = HIGH;
            cnt_n   = ONE;
            if (state == LOW) begin
                period_n  = cnt;
                high_n    = hreg;
                valid_n   = 1'b1;
                timeout_n = 1'b0;
            end
        end else if (fall && state == HIGH) begin
            state_n = LOW;
            hreg_n  = cnt;
        end else if (cnt >= TMO) begin
            state_n   = ARM;
            cnt_n     = '0;
            timeout_n = 1'b1;
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and scoreboarded checks of pwm_capture at default and short TIMEOUT
module tb_pwm_capture;
    logic        clk_in = 1'b0;
    logic        rst, sig_a, sig_b;
    logic [15:0] per_a, hi_a, per_b, hi_b;
    logic        va_a, tmo_a, va_b, tmo_b;
    int          n_tests = 0, n_fail = 0;
    int          va_cnt_a = 0, vb_cnt = 0, cyc = 0, rise_cyc = 0, ph = 0;
    logic        va_prev_a = 1'b0, va_prev_b = 1'b0;
    bit          have_prev = 1'b0;
    int          exp_p[$], exp_h[$];

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    pwm_capture dut_a (
        .clk_in    (clk_in),
        .rst       (rst),
        .sig_in    (sig_a),
        .period    (per_a),
        .high_time (hi_a),
        .valid     (va_a),
        .timeout   (tmo_a)
    );

    pwm_capture #(.TIMEOUT(50)) dut_b (
        .clk_in    (clk_in),
        .rst       (rst),
        .sig_in    (sig_b),
        .period    (per_b),
        .high_time (hi_b),
        .valid     (va_b),
        .timeout   (tmo_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // each rise completes the previous pulse: expected period is the rise-to-rise gap
    task automatic pulse_a(input int h, input int l);
        if (have_prev) begin
            exp_p.push_back(cyc - rise_cyc);
            exp_h.push_back(ph);
        end
        have_prev = 1'b1;
        rise_cyc  = cyc;
        ph        = h;
        sig_a = 1'b1;
        wait_cyc(h);
        sig_a = 1'b0;
        wait_cyc(l);
    endtask

    always @(negedge clk_in) begin
        if (va_a) begin
            va_cnt_a <= va_cnt_a + 1;
            check("valid_dup_a", int'(va_prev_a), 0);
            if (exp_p.size() == 0) check("spurious_valid_a", int'(va_a), 0);
            else begin
                check("period_a", int'(per_a), exp_p.pop_front());
                check("high_time_a", int'(hi_a), exp_h.pop_front());
            end
        end
        if (va_b) begin
            vb_cnt <= vb_cnt + 1;
            check("valid_dup_b", int'(va_prev_b), 0);
        end
        va_prev_a <= va_a;
        va_prev_b <= va_b;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected summary before 100000 cycles");
        $fatal(1);
    end

    initial begin
        int n, base;
        rst   = 1'b1;
        sig_a = 1'b1;
        sig_b = 1'b0;
        wait_cyc(3);
        check("rst_period_a", int'(per_a), 0);
        check("rst_high_a", int'(hi_a), 0);
        check("rst_valid_a", int'(va_a), 0);
        check("rst_timeout_a", int'(tmo_a), 0);
        check("rst_period_b", int'(per_b), 0);
        check("rst_timeout_b", int'(tmo_b), 0);
        rst = 1'b0;
        wait_cyc(12);
        sig_a = 1'b0;
        wait_cyc(10);
        repeat (6) pulse_a(10, 10);
        repeat (2) pulse_a(3, 97);
        repeat (3) pulse_a(1, 1);
        wait_cyc(6);
        check("valids_directed_a", va_cnt_a, 10);
        pulse_a(10, 5);
        rst = 1'b1;
        wait_cyc(1);
        check("midrst_period_a", int'(per_a), 0);
        check("midrst_high_a", int'(hi_a), 0);
        check("midrst_valid_a", int'(va_a), 0);
        check("midrst_timeout_a", int'(tmo_a), 0);
        wait_cyc(1);
        rst = 1'b0;
        have_prev = 1'b0;
        check("valids_before_rst_a", va_cnt_a, 11);
        wait_cyc(8);
        repeat (3) pulse_a(7, 13);
        wait_cyc(6);
        check("valids_after_rst_a", va_cnt_a, 13);
        base = va_cnt_a;
        repeat (150) pulse_a(int'($urandom_range(1, 60)), int'($urandom_range(1, 60)));
        wait_cyc(6);
        check("valids_random_a", va_cnt_a - base, 150);
        check("pending_a", exp_p.size(), 0);
        check("timeout_a", int'(tmo_a), 0);

        sig_b = 1'b1;
        n = 0;
        while (!tmo_b && n < 100) begin
            wait_cyc(1);
            n++;
        end
        check("timeout_latency_b", n, 54);
        check("timeout_period_hold_b", int'(per_b), 0);
        check("timeout_high_hold_b", int'(hi_b), 0);
        check("timeout_no_valid_b", vb_cnt, 0);
        wait_cyc(20);
        sig_b = 1'b0;
        wait_cyc(10);
        sig_b = 1'b1;
        wait_cyc(10);
        sig_b = 1'b0;
        wait_cyc(10);
        check("timeout_sticky_b", int'(tmo_b), 1);
        check("rearm_no_valid_b", vb_cnt, 0);
        sig_b = 1'b1;
        n = 0;
        while (!va_b && n < 20) begin
            wait_cyc(1);
            n++;
        end
        check("valid_latency_b", n, 4);
        check("rearm_period_b", int'(per_b), 20);
        check("rearm_high_b", int'(hi_b), 10);
        check("rearm_timeout_clr_b", int'(tmo_b), 0);
        wait_cyc(10 - n);
        sig_b = 1'b0;
        wait_cyc(40);
        sig_b = 1'b1;
        n = 0;
        while (!va_b && n < 20) begin
            wait_cyc(1);
            n++;
        end
        check("edge_at_tmo_period_b", int'(per_b), 50);
        check("edge_at_tmo_high_b", int'(hi_b), 10);
        check("edge_at_tmo_timeout_b", int'(tmo_b), 0);
        wait_cyc(10 - n);
        sig_b = 1'b0;
        wait_cyc(41);
        sig_b = 1'b1;
        wait_cyc(10);
        check("past_tmo_timeout_b", int'(tmo_b), 1);
        check("past_tmo_period_hold_b", int'(per_b), 50);
        check("past_tmo_high_hold_b", int'(hi_b), 10);
        check("past_tmo_valids_b", vb_cnt, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
